dff_pipe: RTL and testbench
===========================

Name: dff_pipe

Overview:
- Parametrised successor to the single-bit dff: a WIDTH-bit, DEPTH-stage registered pipeline with a valid/ready handshake per stage.
- Bubbles collapse, so a stalled output does not freeze empty upstream stages.
- Used as a generic retiming/delay element between SDRAM controller blocks and test benches.

Parameters:
- WIDTH, 8, data bits per stage (>=1)
- DEPTH, 3, number of register stages (>=1)
- RESET_VAL, 0, value loaded into every data register on reset (WIDTH bits)

Ports:
- clk  input  1  system clock; all state updates on rising edge
- pwr_reset  input  1  synchronous, active-high reset
- i_valid  input  1  upstream data valid
- i_data  input  WIDTH  upstream data
- o_ready  output  1  pipeline can accept i_data this cycle
- o_valid  output  1  output stage holds valid data
- o_data  output  WIDTH  output stage data
- i_ready  input  1  downstream accepts o_data this cycle
- o_count  output  $clog2(DEPTH+1)  number of occupied stages (only with DFF_PIPE_COUNT_EN)

Behaviour:
- One clock (clk); reset is synchronous and active-high (pwr_reset), sampled on the rising edge of clk.
- Reset:
  - all stage valid bits cleared; all data registers load RESET_VAL.
  - o_valid=0, o_data=RESET_VAL.
  - o_ready=1 once reset deasserts; reset takes priority over every transfer in that cycle.
  - Reset mid-operation discards all in-flight data; no transfer completes in the reset cycle.
- Stages: s[0] (input side) to s[DEPTH-1] (output). Each stage has v[k] and d[k].
- Ready chain (combinational):
  - rdy[DEPTH-1] = !v[DEPTH-1] | i_ready
  - rdy[k] = !v[k] | rdy[k+1]
  - o_ready = rdy[0]
- Transfers on each clk edge:
  - Stage 0 loads i_data and sets v[0]=i_valid when rdy[0].
  - Stage k>0 loads d[k-1] and v[k-1] when rdy[k].
  - A stage whose rdy is 0 holds data and valid unchanged.
- Output: o_valid=v[DEPTH-1], o_data=d[DEPTH-1].
  - An output transfer completes when o_valid & i_ready.
- Data registers update only when the loading valid is 1, to limit toggling. A loaded bubble clears v but keeps the old d.
- Latency: empty pipe, i_ready=1 -> data presented at cycle N appears on o_data at cycle N+DEPTH.
- Throughput: 1 word/cycle sustained while i_ready=1.
- Full: all v=1 and i_ready=0 -> o_ready=0; i_data is ignored even if i_valid=1.
- Simultaneous: full pipe with i_ready=1 -> o_ready=1; in-transfer and out-transfer occur in the same cycle; occupancy unchanged.
- Bubble collapse: i_ready=0 with partial occupancy -> upstream stages keep advancing until contiguous behind the output stage.
- Combinational path i_ready->o_ready is permitted. Max DEPTH is limited by timing, not by function.
- Ordering: words exit in entry order. No duplication or loss except on reset.

Optional Feature:
- Macro: DFF_PIPE_COUNT_EN.
- Defined:
  - o_count port present; o_count equals the number of set v bits, registered and updated on the same edge as v.
  - Reset value 0; range 0..DEPTH.
  - Implement as an up/down counter: +1 on input transfer without output transfer, -1 on output transfer without input transfer, otherwise hold.
- Undefined: o_count port and counter logic absent. All other behaviour identical.

Test Plan:
- Reset, WIDTH=8, DEPTH=3, RESET_VAL=8'hA5: pwr_reset=1 for 2 cycles -> o_valid=0, o_data=8'hA5, o_ready=1 after release, o_count=0.
- Latency: i_ready=1; send 8'h11 at cycle 0 with single-cycle i_valid -> o_valid=1 with o_data=8'h11 at cycle 3 only, for one cycle.
- Streaming: i_ready=1; send 8'h01..8'h10 back-to-back -> 16 outputs on consecutive cycles starting at cycle 3, in order; o_ready stays 1.
- Backpressure/full: i_ready=0, send 8'h21,8'h22,8'h23,8'h24 -> o_ready=0 after 3 accepts, 8'h24 held off, o_count=3.
  - Then i_ready=1 -> outputs 21,22,23,24 in order, with 8'h24 accepted in the same cycle 8'h21 leaves.
- Bubble collapse: i_ready=0; inject 8'h31 at cycle 0, idle, 8'h32 at cycle 2 -> by cycle 5 v=3'b110 ({v[2],v[1],v[0]}), with 8'h31 at output and 8'h32 in s[1]; o_ready=1.
- Reset mid-stream: pipe holding 3 words, assert pwr_reset 1 cycle -> next cycle o_valid=0, o_count=0, o_data=RESET_VAL; no stale word emerges afterwards.

Source files
------------

// File: rtl/dff_pipe.sv
// WIDTH-bit, DEPTH-stage valid/ready register pipeline whose bubbles collapse behind a stalled output.
// Optional occupancy counter o_count is enabled with `define DFF_PIPE_COUNT_EN.
module dff_pipe #(
  parameter int               WIDTH     = 8,
  parameter int               DEPTH     = 3,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                           clk,
  input  logic                           pwr_reset,
  input  logic                           i_valid,
  input  logic [WIDTH-1:0]               i_data,
  output logic                           o_ready,
  input  logic                           i_ready,
  output logic                           o_valid,
  output logic [WIDTH-1:0]               o_data
`ifdef DFF_PIPE_COUNT_EN
  ,
  output logic [$clog2(DEPTH+1)-1:0]     o_count
`endif
);

  logic [DEPTH-1:0] v;
  logic [DEPTH-1:0] rdy;
  logic [WIDTH-1:0] d [DEPTH];

  // A stage can load when it is empty or everything downstream of it can move.
  always_comb begin
    logic r;
    rdy = '0;
    r = !v[DEPTH-1] | i_ready;
    rdy[DEPTH-1] = r;
    for (int k = DEPTH - 2; k >= 0; k--) begin
      r = !v[k] | r;
      rdy[k] = r;
    end
  end

  always_ff @(posedge clk) begin
    if (pwr_reset) begin
      v <= '0;
      for (int k = 0; k < DEPTH; k++) d[k] <= RESET_VAL;
    end else begin
      if (rdy[0]) begin
        v[0] <= i_valid;
        if (i_valid) d[0] <= i_data;
      end
      // A loaded bubble clears valid but leaves the old data in place.
      for (int k = 1; k < DEPTH; k++) begin
        if (rdy[k]) begin
          v[k] <= v[k-1];
          if (v[k-1]) d[k] <= d[k-1];
        end
      end
    end
  end

  assign o_ready = rdy[0];
  assign o_valid = v[DEPTH-1];
  assign o_data  = d[DEPTH-1];

`ifdef DFF_PIPE_COUNT_EN
  localparam int CW = $clog2(DEPTH + 1);

  logic          in_xfer;
  logic          out_xfer;
  logic [CW-1:0] count;

  assign in_xfer  = i_valid & rdy[0];
  assign out_xfer = v[DEPTH-1] & i_ready;

  always_ff @(posedge clk) begin
    if (pwr_reset) begin
      count <= '0;
    end else if (in_xfer && !out_xfer) begin
      count <= count + CW'(1);
    end else if (out_xfer && !in_xfer) begin
      count <= count - CW'(1);
    end
  end

  assign o_count = count;
`endif

endmodule

// File: tb/tb_dff_pipe.sv
// Directed self-checking bench for dff_pipe at WIDTH=8, DEPTH=3, RESET_VAL=8'hA5.
// Occupancy checks are included when DFF_PIPE_COUNT_EN is defined.
module tb_dff_pipe;

  logic       clk = 1'b0;
  logic       pwr_reset = 1'b1;
  logic       i_valid = 1'b0;
  logic [7:0] i_data = 8'h00;
  logic       o_ready;
  logic       i_ready = 1'b0;
  logic       o_valid;
  logic [7:0] o_data;
`ifdef DFF_PIPE_COUNT_EN
  logic [1:0] o_count;
`endif

  int checks = 0;
  int passes = 0;

  dff_pipe #(.WIDTH(8), .DEPTH(3), .RESET_VAL(8'hA5)) dut (
    .clk       (clk),
    .pwr_reset (pwr_reset),
    .i_valid   (i_valid),
    .i_data    (i_data),
    .o_ready   (o_ready),
    .i_ready   (i_ready),
    .o_valid   (o_valid),
    .o_data    (o_data)
`ifdef DFF_PIPE_COUNT_EN
    ,
    .o_count   (o_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    pwr_reset = 1'b1;
    i_valid   = 1'b0;
    tick();
    tick();
    pwr_reset = 1'b0;
  endtask

  task automatic test_reset();
    i_ready = 1'b0;
    do_reset();
    checks++;
    if (o_valid !== 1'b0) $display("FAIL reset_o_valid got %b want 0", o_valid);
    else passes++;
    checks++;
    if (o_data !== 8'hA5) $display("FAIL reset_o_data got %h want a5", o_data);
    else passes++;
    #1;
    checks++;
    if (o_ready !== 1'b1) $display("FAIL reset_o_ready got %b want 1", o_ready);
    else passes++;
`ifdef DFF_PIPE_COUNT_EN
    checks++;
    if (o_count !== 2'd0) $display("FAIL reset_o_count got %0d want 0", o_count);
    else passes++;
`endif
  endtask

  task automatic test_latency();
    logic exp_v;
    do_reset();
    i_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      i_valid = (c == 0);
      i_data  = 8'h11;
      tick();
      exp_v = (c == 2);
      checks++;
      if (o_valid !== exp_v) $display("FAIL latency_valid c=%0d got %b want %b", c, o_valid, exp_v);
      else passes++;
      if (exp_v) begin
        checks++;
        if (o_data !== 8'h11) $display("FAIL latency_data got %h want 11", o_data);
        else passes++;
      end
    end
    i_valid = 1'b0;
  endtask

  task automatic test_streaming();
    logic       exp_v;
    logic [7:0] exp_d;
    do_reset();
    i_ready = 1'b1;
    for (int c = 0; c < 19; c++) begin
      i_valid = (c < 16);
      i_data  = 8'(c + 1);
      #1;
      if (c < 16) begin
        checks++;
        if (o_ready !== 1'b1) $display("FAIL stream_ready c=%0d got %b want 1", c, o_ready);
        else passes++;
      end
      tick();
      exp_v = (c >= 2) && (c < 18);
      exp_d = 8'(c - 1);
      checks++;
      if (o_valid !== exp_v) $display("FAIL stream_valid c=%0d got %b want %b", c, o_valid, exp_v);
      else passes++;
      if (exp_v) begin
        checks++;
        if (o_data !== exp_d) $display("FAIL stream_data c=%0d got %h want %h", c, o_data, exp_d);
        else passes++;
      end
    end
    i_valid = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [7:0] words [4];
    words[0] = 8'h21; words[1] = 8'h22; words[2] = 8'h23; words[3] = 8'h24;
    do_reset();
    i_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      i_valid = 1'b1;
      i_data  = words[c];
      #1;
      checks++;
      if (o_ready !== 1'b1) $display("FAIL bp_accept_ready c=%0d got %b want 1", c, o_ready);
      else passes++;
      tick();
    end
    i_valid = 1'b1;
    i_data  = 8'h24;
    for (int c = 0; c < 2; c++) begin
      #1;
      checks++;
      if (o_ready !== 1'b0) $display("FAIL bp_full_ready c=%0d got %b want 0", c, o_ready);
      else passes++;
      tick();
    end
    checks++;
    if (o_valid !== 1'b1 || o_data !== 8'h21)
      $display("FAIL bp_full_head got v=%b d=%h want v=1 d=21", o_valid, o_data);
    else passes++;
`ifdef DFF_PIPE_COUNT_EN
    checks++;
    if (o_count !== 2'd3) $display("FAIL bp_full_count got %0d want 3", o_count);
    else passes++;
`endif
    i_ready = 1'b1;
    #1;
    checks++;
    if (o_ready !== 1'b1) $display("FAIL bp_simul_ready got %b want 1", o_ready);
    else passes++;
    tick();
    i_valid = 1'b0;
    for (int c = 1; c < 4; c++) begin
      checks++;
      if (o_valid !== 1'b1 || o_data !== words[c])
        $display("FAIL bp_drain c=%0d got v=%b d=%h want v=1 d=%h", c, o_valid, o_data, words[c]);
      else passes++;
`ifdef DFF_PIPE_COUNT_EN
      if (c == 1) begin
        checks++;
        if (o_count !== 2'd3) $display("FAIL bp_simul_count got %0d want 3", o_count);
        else passes++;
      end
`endif
      tick();
    end
    checks++;
    if (o_valid !== 1'b0) $display("FAIL bp_empty_valid got %b want 0", o_valid);
    else passes++;
  endtask

  task automatic test_bubble_collapse();
    do_reset();
    i_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      i_valid = (c == 0) || (c == 2);
      i_data  = (c == 0) ? 8'h31 : 8'h32;
      tick();
    end
    i_valid = 1'b0;
    #1;
    checks++;
    if (o_valid !== 1'b1 || o_data !== 8'h31)
      $display("FAIL bubble_head got v=%b d=%h want v=1 d=31", o_valid, o_data);
    else passes++;
    checks++;
    if (o_ready !== 1'b1) $display("FAIL bubble_ready got %b want 1", o_ready);
    else passes++;
`ifdef DFF_PIPE_COUNT_EN
    checks++;
    if (o_count !== 2'd2) $display("FAIL bubble_count got %0d want 2", o_count);
    else passes++;
`endif
    // 8'h32 must sit directly behind the head, so it appears on the very next release edge.
    i_ready = 1'b1;
    tick();
    checks++;
    if (o_valid !== 1'b1 || o_data !== 8'h32)
      $display("FAIL bubble_second got v=%b d=%h want v=1 d=32", o_valid, o_data);
    else passes++;
    tick();
    checks++;
    if (o_valid !== 1'b0) $display("FAIL bubble_drained got %b want 0", o_valid);
    else passes++;
  endtask

  task automatic test_reset_midstream();
    do_reset();
    i_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      i_valid = 1'b1;
      i_data  = 8'(8'h41 + c);
      tick();
    end
    pwr_reset = 1'b1;
    i_valid   = 1'b1;
    i_data    = 8'h44;
    i_ready   = 1'b1;
    tick();
    pwr_reset = 1'b0;
    i_valid   = 1'b0;
    checks++;
    if (o_valid !== 1'b0 || o_data !== 8'hA5)
      $display("FAIL midreset_out got v=%b d=%h want v=0 d=a5", o_valid, o_data);
    else passes++;
`ifdef DFF_PIPE_COUNT_EN
    checks++;
    if (o_count !== 2'd0) $display("FAIL midreset_count got %0d want 0", o_count);
    else passes++;
`endif
    for (int c = 0; c < 5; c++) begin
      tick();
      checks++;
      if (o_valid !== 1'b0) $display("FAIL midreset_stale c=%0d got v=%b d=%h want v=0", c, o_valid, o_data);
      else passes++;
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_streaming();
    test_backpressure();
    test_bubble_collapse();
    test_reset_midstream();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
